// File: rtl/ascensor_pkg.sv
// rtl/ascensor_pkg.sv - encodings shared by the elevator controller and the car emulator
package ascensor_pkg;

  localparam logic [1:0] MOTOR_PARO = 2'b00;
  localparam logic [1:0] MOTOR_SUBE = 2'b01;
  localparam logic [1:0] MOTOR_BAJA = 2'b10;

  localparam logic [1:0] PUERTA_MANTENER = 2'b00;
  localparam logic [1:0] PUERTA_ABRIR    = 2'b01;
  localparam logic [1:0] PUERTA_CERRAR   = 2'b10;

  localparam logic [1:0] CERRADA = 2'b00;
  localparam logic [1:0] PARCIAL = 2'b01;
  localparam logic [1:0] ABIERTA = 2'b11;

  localparam logic [1:0] FALLA_NINGUNA      = 2'b00;
  localparam logic [1:0] FALLA_MOVIMIENTO   = 2'b01;
  localparam logic [1:0] FALLA_SOBRECARRERA = 2'b10;
  localparam logic [1:0] FALLA_PUERTA       = 2'b11;

  // Simultaneous faults resolve to the lowest code.
  function automatic logic [1:0] codigo_prioritario(input logic mov, input logic sobre,
                                                    input logic puerta);
    if (mov)         return FALLA_MOVIMIENTO;
    else if (sobre)  return FALLA_SOBRECARRERA;
    else if (puerta) return FALLA_PUERTA;
    else             return FALLA_NINGUNA;
  endfunction

endpackage

// File: rtl/modelo_puerta.sv
// rtl/modelo_puerta.sv - door travel counter with saturation, obstruction hold and state decode
module modelo_puerta
  import ascensor_pkg::*;
#(
  parameter int CICLOS_PUERTA = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] puertas,
  input  logic       obstaculo,
  input  logic       en_piso,
  output logic       cerrada,
  output logic [1:0] puertas_abiertas,
  output logic       sensor_puertas,
  output logic       falla_puerta
);

  localparam int PW = $clog2(CICLOS_PUERTA + 1);
  localparam logic [PW-1:0] POS_MAX = PW'(CICLOS_PUERTA);

  logic [PW-1:0] pos, pos_next;
  logic [1:0]    estado_next;

  always_comb begin
    pos_next     = pos;
    falla_puerta = 1'b0;
    case (puertas)
      PUERTA_ABRIR: begin
        if (!en_piso)           falla_puerta = 1'b1;
        else if (pos != POS_MAX) pos_next = pos + 1'b1;
      end
      PUERTA_CERRAR: begin
        if (!obstaculo && pos != '0) pos_next = pos - 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    estado_next = PARCIAL;
    if (pos_next == '0)          estado_next = CERRADA;
    else if (pos_next == POS_MAX) estado_next = ABIERTA;
  end

  // The car interlock looks at the door position before this cycle's update.
  assign cerrada = (pos == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos              <= '0;
      puertas_abiertas <= CERRADA;
      sensor_puertas   <= 1'b0;
    end else begin
      pos              <= pos_next;
      puertas_abiertas <= estado_next;
      sensor_puertas   <= obstaculo && (pos_next != '0);
    end
  end

endmodule

// File: rtl/emulador_cabina.sv
// rtl/emulador_cabina.sv - elevator car, shaft and door plant model with illegal-command detection
module emulador_cabina
  import ascensor_pkg::*;
#(
  parameter int CICLOS_PISO   = 16,
  parameter int CICLOS_PUERTA = 8,
  parameter int PISO_INICIAL  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] motor,
  input  logic [1:0] puertas,
  input  logic       obstaculo,
  output logic       cambio_piso,
  output logic [1:0] puertas_abiertas,
  output logic       sensor_puertas,
  output logic [1:0] piso_actual,
  output logic       falla,
  output logic [1:0] codigo_falla
);

  localparam int DW = $clog2(CICLOS_PISO);
  localparam logic [DW-1:0] DESP_MAX   = DW'(CICLOS_PISO - 1);
  localparam logic [DW-1:0] DESP_UNO   = DW'(1);
  localparam logic [1:0]    PISO_RESET = 2'(PISO_INICIAL);

  logic [1:0]    piso_base, piso_base_next;
  logic [DW-1:0] desp, desp_next;
  logic          llegada, en_piso, cerrada, sube, baja;
  logic          falla_mov, falla_sobre, falla_puerta;

  assign en_piso = (desp == '0);
  assign sube    = (motor == MOTOR_SUBE);
  assign baja    = (motor == MOTOR_BAJA);

  modelo_puerta #(.CICLOS_PUERTA(CICLOS_PUERTA)) u_puerta (
    .clk              (clk),
    .rst_n            (rst_n),
    .puertas          (puertas),
    .obstaculo        (obstaculo),
    .en_piso          (en_piso),
    .cerrada          (cerrada),
    .puertas_abiertas (puertas_abiertas),
    .sensor_puertas   (sensor_puertas),
    .falla_puerta     (falla_puerta)
  );

  always_comb begin
    piso_base_next = piso_base;
    desp_next      = desp;
    llegada        = 1'b0;
    falla_mov      = (sube || baja) && !cerrada;
    falla_sobre    = en_piso && ((sube && piso_base == 2'd3) || (baja && piso_base == 2'd0));
    if (cerrada && !falla_sobre) begin
      if (sube) begin
        if (desp != DESP_MAX) begin
          desp_next = desp + 1'b1;
        end else begin
          desp_next      = '0;
          piso_base_next = piso_base + 2'd1;
          llegada        = 1'b1;
        end
      end else if (baja) begin
        if (desp > DESP_UNO) begin
          desp_next = desp - 1'b1;
        end else if (desp == DESP_UNO) begin
          desp_next = '0;
          llegada   = 1'b1;
        end else begin
          // Leaving a floor downward: the segment now belongs to the floor below.
          piso_base_next = piso_base - 2'd1;
          desp_next      = DESP_MAX;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      piso_base    <= PISO_RESET;
      desp         <= '0;
      piso_actual  <= PISO_RESET;
      cambio_piso  <= 1'b0;
      falla        <= 1'b0;
      codigo_falla <= FALLA_NINGUNA;
    end else begin
      piso_base   <= piso_base_next;
      desp        <= desp_next;
      cambio_piso <= llegada;
      if (llegada) piso_actual <= piso_base_next;
      if (!falla && (falla_mov || falla_sobre || falla_puerta)) begin
        falla        <= 1'b1;
        codigo_falla <= codigo_prioritario(falla_mov, falla_sobre, falla_puerta);
      end
    end
  end

endmodule

// File: tb/tb_emulador_cabina.sv
// tb/tb_emulador_cabina.sv - scoreboard bench for emulador_cabina
module tb_emulador_cabina;
  import ascensor_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] motor = 2'b00, puertas = 2'b00, motor_b = 2'b00;
  logic       obstaculo = 1'b0;

  logic       cp_a, sp_a, f_a, cp_b, sp_b, f_b;
  logic [1:0] pa_a, piso_a, cod_a, pa_b, piso_b, cod_b;

  typedef struct {
    logic [8:0] v;
    string      name;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  emulador_cabina #(.CICLOS_PISO(16), .CICLOS_PUERTA(8), .PISO_INICIAL(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .motor(motor), .puertas(puertas), .obstaculo(obstaculo),
    .cambio_piso(cp_a), .puertas_abiertas(pa_a), .sensor_puertas(sp_a),
    .piso_actual(piso_a), .falla(f_a), .codigo_falla(cod_a)
  );

  emulador_cabina #(.CICLOS_PISO(16), .CICLOS_PUERTA(8), .PISO_INICIAL(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .motor(motor_b), .puertas(2'b00), .obstaculo(1'b0),
    .cambio_piso(cp_b), .puertas_abiertas(pa_b), .sensor_puertas(sp_b),
    .piso_actual(piso_b), .falla(f_b), .codigo_falla(cod_b)
  );

  // Expected vector layout: {cambio_piso, puertas_abiertas, sensor_puertas, piso_actual, falla, codigo_falla}
  function automatic exp_t mk(input logic cp, input logic [1:0] pa, input logic sp,
                              input logic [1:0] piso, input logic f, input logic [1:0] cod,
                              input string name);
    exp_t e;
    e.v    = {cp, pa, sp, piso, f, cod};
    e.name = name;
    return e;
  endfunction

  task automatic chk(input exp_t e, input logic [8:0] act);
    checks++;
    if (act !== e.v) begin
      errors++;
      $display("FAIL %s: got cp=%b pa=%b sp=%b piso=%0d falla=%b cod=%b, expected cp=%b pa=%b sp=%b piso=%0d falla=%b cod=%b",
               e.name, act[8], act[7:6], act[5], act[4:3], act[2], act[1:0],
               e.v[8], e.v[7:6], e.v[5], e.v[4:3], e.v[2], e.v[1:0]);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk(e, {cp_a, pa_a, sp_a, piso_a, f_a, cod_a});
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk(e, {cp_b, pa_b, sp_b, piso_b, f_b, cod_b});
      end
    end
  end

  task automatic step(input logic [1:0] m, input logic [1:0] p, input logic o,
                      input logic cp, input logic [1:0] pa, input logic sp,
                      input logic [1:0] piso, input logic f, input logic [1:0] cod,
                      input string name);
    @(negedge clk);
    motor = m; puertas = p; obstaculo = o;
    qa.push_back(mk(cp, pa, sp, piso, f, cod, name));
  endtask

  task automatic step_b(input logic [1:0] m, input logic cp, input logic [1:0] piso,
                        input logic f, input logic [1:0] cod, input string name);
    @(negedge clk);
    motor_b = m;
    qb.push_back(mk(cp, CERRADA, 1'b0, piso, f, cod, name));
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    motor = 2'b00; puertas = 2'b00; obstaculo = 1'b0; motor_b = 2'b00;
    qa.push_back(mk(1'b0, CERRADA, 1'b0, 2'd0, 1'b0, FALLA_NINGUNA, name));
    qb.push_back(mk(1'b0, CERRADA, 1'b0, 2'd3, 1'b0, FALLA_NINGUNA, {name, "_b"}));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic async_reset(input string name);
    @(posedge clk);
    #3;
    motor = 2'b00; puertas = 2'b00; obstaculo = 1'b0; motor_b = 2'b00;
    qa.push_back(mk(1'b0, CERRADA, 1'b0, 2'd0, 1'b0, FALLA_NINGUNA, name));
    qb.push_back(mk(1'b0, CERRADA, 1'b0, 2'd3, 1'b0, FALLA_NINGUNA, {name, "_b"}));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  localparam logic [1:0] P = MOTOR_PARO, U = MOTOR_SUBE, D = MOTOR_BAJA;
  localparam logic [1:0] H = PUERTA_MANTENER, O = PUERTA_ABRIR, C = PUERTA_CERRAR;

  initial begin : stimulus
    do_reset("reset");

    for (int i = 1; i <= 16; i++)
      step(U, H, 0, i == 16, CERRADA, 0, (i == 16) ? 2'd1 : 2'd0, 0, 2'b00, "up16");
    step(P, H, 0, 0, CERRADA, 0, 2'd1, 0, 2'b00, "stop_f1");

    for (int i = 1; i <= 5; i++)
      step(U, H, 0, 0, CERRADA, 0, 2'd1, 0, 2'b00, "up5");
    for (int i = 1; i <= 5; i++)
      step(D, H, 0, i == 5, CERRADA, 0, 2'd1, 0, 2'b00, "down5_return");
    step(P, H, 0, 0, CERRADA, 0, 2'd1, 0, 2'b00, "stop_return");

    for (int i = 1; i <= 16; i++)
      step(D, H, 0, i == 16, CERRADA, 0, (i == 16) ? 2'd0 : 2'd1, 0, 2'b00, "down16");

    for (int i = 1; i <= 8; i++)
      step(P, O, 0, 0, (i == 8) ? ABIERTA : PARCIAL, 0, 2'd0, 0, 2'b00, "open8");
    step(P, O, 0, 0, ABIERTA, 0, 2'd0, 0, 2'b00, "open_saturate");
    for (int i = 1; i <= 4; i++)
      step(P, C, 1, 0, ABIERTA, 1, 2'd0, 0, 2'b00, "close_obstructed");
    for (int i = 1; i <= 8; i++)
      step(P, C, 0, 0, (i == 8) ? CERRADA : PARCIAL, 0, 2'd0, 0, 2'b00, "close8");
    step(P, C, 1, 0, CERRADA, 0, 2'd0, 0, 2'b00, "obst_door_closed");

    step(U, O, 0, 0, PARCIAL, 0, 2'd0, 0, 2'b00, "open_and_move");
    step(U, H, 0, 0, PARCIAL, 0, 2'd0, 1, FALLA_MOVIMIENTO, "move_door_ajar");
    step(P, O, 0, 0, PARCIAL, 0, 2'd0, 1, FALLA_MOVIMIENTO, "open_off_floor_keep01");
    step(P, C, 0, 0, CERRADA, 0, 2'd0, 1, FALLA_MOVIMIENTO, "close1");
    for (int i = 1; i <= 15; i++)
      step(U, H, 0, i == 15, CERRADA, 0, (i == 15) ? 2'd1 : 2'd0, 1, FALLA_MOVIMIENTO, "up15_after_hold");

    for (int i = 1; i <= 8; i++)
      step(P, O, 0, 0, (i == 8) ? ABIERTA : PARCIAL, 0, 2'd1, 1, FALLA_MOVIMIENTO, "open8_f1");
    step(U, H, 0, 0, ABIERTA, 0, 2'd1, 1, FALLA_MOVIMIENTO, "move_door_open");
    for (int i = 1; i <= 8; i++)
      step(P, C, 0, 0, (i == 8) ? CERRADA : PARCIAL, 0, 2'd1, 1, FALLA_MOVIMIENTO, "close8_f1");
    for (int i = 1; i <= 16; i++)
      step(D, H, 0, i == 16, CERRADA, 0, (i == 16) ? 2'd0 : 2'd1, 1, FALLA_MOVIMIENTO, "down16_f1");
    step(D, H, 0, 0, CERRADA, 0, 2'd0, 1, FALLA_MOVIMIENTO, "overtravel_keeps01");

    for (int i = 1; i <= 5; i++)
      step(U, H, 0, 0, CERRADA, 0, 2'd0, 1, FALLA_MOVIMIENTO, "up_mid_segment");
    async_reset("async_reset");

    for (int i = 1; i <= 16; i++)
      step(U, H, 0, i == 16, CERRADA, 0, (i == 16) ? 2'd1 : 2'd0, 0, 2'b00, "up16_after_reset");
    for (int i = 1; i <= 3; i++)
      step(U, H, 0, 0, CERRADA, 0, 2'd1, 0, 2'b00, "up3");
    step(P, O, 0, 0, CERRADA, 0, 2'd1, 1, FALLA_PUERTA, "open_off_floor");
    step(P, H, 0, 0, CERRADA, 0, 2'd1, 1, FALLA_PUERTA, "hold_code11");

    do_reset("reset2");
    step_b(U, 0, 2'd3, 1, FALLA_SOBRECARRERA, "b_overtravel_up");
    step_b(P, 0, 2'd3, 1, FALLA_SOBRECARRERA, "b_stop");
    for (int i = 1; i <= 16; i++)
      step_b(D, i == 16, (i == 16) ? 2'd2 : 2'd3, 1, FALLA_SOBRECARRERA, "b_down16");

    @(negedge clk);
    motor_b = 2'b00;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: got %0d/%0d pending, expected 0/0", qa.size(), qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
